fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//  Host-side writer for the FIR accelerator coefficient port. Accepts NUM_REGS
//  coefficients over a valid/ready stream and sequences the FIR control inputs:
//  - drives coeffWriteEn/coeffAddress/coeffsIn
//  - holds accelerateEn low during a load, then pulses clrC
//  - re-enables the datapath only after a complete, accepted coefficient set
// PARAMETERS
//  DATA_WIDTH  `DATA_WIDTH  coefficient width, signed fixed-point (Q_FORMAT)
//  NUM_REGS    `NUM_REGS    number of coefficient registers / taps
//  ADDR_WIDTH  3            coeffAddress width; must satisfy 2**ADDR_WIDTH >= NUM_REGS
// PORTS
//  clk           in   1           system clock, rising edge
//  rstN          in   1           asynchronous, active-low reset
//  startLoad     in   1           1-cycle request to begin a coefficient load
//  abortLoad     in   1           abandon the load in progress
//  hostCoeff     in   DATA_WIDTH  signed coefficient from host
//  hostValid     in   1           hostCoeff valid
//  hostReady     out  1           loader accepts hostCoeff this cycle
//  coeffWriteEn  out  1           to FIR: coefficient write strobe
//  coeffAddress  out  ADDR_WIDTH  to FIR: write address
//  coeffsIn      out  DATA_WIDTH  to FIR: write data
//  accelerateEn  out  1           to FIR: datapath enable
//  clrC          out  1           to FIR: clear delay line / accumulator
//  busy          out  1           high in any state other than IDLE
//  loadDone      out  1           1-cycle pulse at the end of a load
//  hostChecksum  in   DATA_WIDTH  (FIR_COEFF_CHECKSUM_EN only) expected sum
//  checksumErr   out  1           (FIR_COEFF_CHECKSUM_EN only) sticky mismatch flag
// BEHAVIOUR
//  - All outputs are registered except hostReady.
//  - Reset values: every output 0, state IDLE, count 0, coeffsValid 0.
//    accelerateEn therefore stays low until the first successful load.
//  - accelerateEn = coeffsValid && (state == IDLE).
//  - hostReady = (state == LOAD).
//  - IDLE:  on startLoad, go to HALT. Clear count and coeffsValid.
//  - HALT:  one cycle with accelerateEn=0 so the FIR drains the current sample.
//           Go to LOAD.
//  - LOAD:  each cycle with hostValid && hostReady is one accept.
//           The next cycle drives coeffWriteEn=1, coeffAddress=count (first
//           coefficient at address 0, no pre-increment), coeffsIn=hostCoeff.
//           count then increments. coeffWriteEn is 0 in cycles with no accept.
//           After the accept with count == NUM_REGS-1, go to CLEAR. That final
//           write strobe coincides with the first CLEAR cycle.
//  - CLEAR: clrC=1 for exactly 1 cycle. Go to DONE.
//  - DONE:  loadDone=1 for 1 cycle, set coeffsValid=1, go to IDLE.
//           accelerateEn rises on the following cycle.
//  - Minimum latency: startLoad to loadDone = NUM_REGS+3 cycles with hostValid
//    held high. hostValid stalls extend LOAD without limit.
//  - startLoad while busy is ignored.
//  - abortLoad in HALT, LOAD or CLEAR: go to IDLE next cycle. coeffsValid stays
//    0, no loadDone pulse, no further write strobes (a strobe already registered
//    still completes). abortLoad has priority over an accept in the same cycle.
//  - abortLoad in IDLE or DONE is ignored.
//  - rstN asserted mid-load: immediate return to reset values. The FIR
//    coefficients may be partial, so the datapath stays disabled.
//  - count never wraps: LOAD exits at NUM_REGS accepts.
// CONFIGURATION
//  FIR_COEFF_CHECKSUM_EN defined:
//  - hostChecksum is sampled on startLoad.
//  - A running sum of accepted coefficients, modulo 2**DATA_WIDTH, is kept.
//  - In CLEAR the sum is compared with the sampled hostChecksum. On mismatch:
//    checksumErr=1 (sticky until the next accepted startLoad), coeffsValid
//    stays 0, loadDone still pulses.
//  FIR_COEFF_CHECKSUM_EN undefined:
//  - hostChecksum and checksumErr ports are absent.
//  - No sum logic. Every completed load sets coeffsValid.
// TESTING
//  1. Reset, then idle 5 cycles -> all outputs 0, accelerateEn=0.
//  2. startLoad, then NUM_REGS coeffs of r2f(0.2) with hostValid held high ->
//     writes to addr 0..NUM_REGS-1 on consecutive cycles; clrC 1 cycle;
//     loadDone at NUM_REGS+3 cycles; accelerateEn=1 the next cycle.
//  3. Load with hostValid low for 2 cycles after the 3rd coeff ->
//     coeffWriteEn gaps of 2 cycles; addresses stay contiguous 0..7;
//     loadDone is 2 cycles later than in test 2.
//  4. abortLoad after 4 accepts -> busy falls next cycle; exactly 4 write
//     strobes; no clrC; no loadDone; accelerateEn stays 0.
//  5. rstN pulsed low during LOAD, then startLoad pulsed in the cycle after
//     release -> outputs 0 during reset; a full reload completes normally.
//  6. [CHECKSUM_EN] Load of all coeffs = i2f(1) with hostChecksum = 8*i2f(1)
//     -> checksumErr=0, accelerateEn=1. Repeat with hostChecksum off by 1 ->
//     checksumErr=1, loadDone pulses, accelerateEn stays 0.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the FIR accelerator: valid/ready stream in, FIR coefficient port out.
// Ports: clk, rstN, startLoad, abortLoad, hostCoeff/hostValid/hostReady, coeffWriteEn/
//   coeffAddress/coeffsIn, accelerateEn, clrC, busy, loadDone.
//   The ports hostChecksum and checksumErr exist only when FIR_COEFF_CHECKSUM_EN is defined.
module fir_coeff_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  startLoad,
    input  logic                  abortLoad,
    input  logic [DATA_WIDTH-1:0] hostCoeff,
    input  logic                  hostValid,
    output logic                  hostReady,
    output logic                  coeffWriteEn,
    output logic [ADDR_WIDTH-1:0] coeffAddress,
    output logic [DATA_WIDTH-1:0] coeffsIn,
    output logic                  accelerateEn,
    output logic                  clrC,
    output logic                  busy,
    output logic                  loadDone
`ifdef FIR_COEFF_CHECKSUM_EN
    ,
    input  logic [DATA_WIDTH-1:0] hostChecksum,
    output logic                  checksumErr
`endif
);

    typedef enum logic [2:0] {
        IDLE, HALT, LOAD, CLEAR, DONE
    } state_t;

    // One spare bit so the count can reach NUM_REGS without wrapping.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(NUM_REGS - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  accel_q, accel_d;
    logic                  clr_q, clr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;
`ifdef FIR_COEFF_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic                  err_q, err_d;
`endif

    // Abort wins over an accept in the same cycle.
    assign accept = (state_q == LOAD) && hostValid && !abortLoad;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        valid_d = valid_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef FIR_COEFF_CHECKSUM_EN
        sum_d   = sum_q;
        chk_d   = chk_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (startLoad) begin
                    state_d = HALT;
                    count_d = '0;
                    valid_d = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d   = '0;
                    chk_d   = hostChecksum;
                    err_d   = 1'b0;
`endif
                end
            end
            HALT: begin
                state_d = abortLoad ? IDLE : LOAD;
            end
            LOAD: begin
                if (abortLoad) begin
                    state_d = IDLE;
                end else if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_WIDTH-1:0];
                    data_d  = hostCoeff;
                    count_d = count_q + ONE;
`ifdef FIR_COEFF_CHECKSUM_EN
                    sum_d   = sum_q + hostCoeff;
`endif
                    if (count_q == LAST) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (abortLoad) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
`ifdef FIR_COEFF_CHECKSUM_EN
                    if (sum_q != chk_q) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef FIR_COEFF_CHECKSUM_EN
                valid_d = !err_q;
`else
                valid_d = 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        accel_d = valid_d && (state_d == IDLE);
        clr_d   = (state_d == CLEAR);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            count_q <= '0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            accel_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_q   <= '0;
            chk_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            accel_q <= accel_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_q   <= sum_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
`endif
        end
    end

    assign hostReady    = (state_q == LOAD);
    assign coeffWriteEn = we_q;
    assign coeffAddress = addr_q;
    assign coeffsIn     = data_q;
    assign accelerateEn = accel_q;
    assign clrC         = clr_q;
    assign busy         = busy_q;
    assign loadDone     = done_q;
`ifdef FIR_COEFF_CHECKSUM_EN
    assign checksumErr  = err_q;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: expected writes queued at accept,
// popped by a monitor on the falling edge.
module tb_fir_coeff_loader;

    localparam int N = 8;

    logic        clk;
    logic        rstN;
    logic        startLoad;
    logic        abortLoad;
    logic [15:0] hostCoeff;
    logic        hostValid;
    logic        hostReady;
    logic        coeffWriteEn;
    logic [2:0]  coeffAddress;
    logic [15:0] coeffsIn;
    logic        accelerateEn;
    logic        clrC;
    logic        busy;
    logic        loadDone;
`ifdef FIR_COEFF_CHECKSUM_EN
    logic [15:0] hostChecksum;
    logic        checksumErr;
`endif

    fir_coeff_loader #(.DATA_WIDTH(16), .NUM_REGS(N), .ADDR_WIDTH(3)) dut (
        .clk(clk),
        .rstN(rstN),
        .startLoad(startLoad),
        .abortLoad(abortLoad),
        .hostCoeff(hostCoeff),
        .hostValid(hostValid),
        .hostReady(hostReady),
        .coeffWriteEn(coeffWriteEn),
        .coeffAddress(coeffAddress),
        .coeffsIn(coeffsIn),
        .accelerateEn(accelerateEn),
        .clrC(clrC),
        .busy(busy),
        .loadDone(loadDone)
`ifdef FIR_COEFF_CHECKSUM_EN
        ,
        .hostChecksum(hostChecksum),
        .checksumErr(checksumErr)
`endif
    );

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  nClr = 0;
    int  nDone = 0;
    int  clrCyc = 0;
    int  doneCyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count pulses and check every write strobe against the queue.
    always @(negedge clk) begin
        if (rstN) begin
            if (clrC) begin
                nClr++;
                clrCyc = cyc;
            end
            if (loadDone) begin
                nDone++;
                doneCyc = cyc;
            end
            if (coeffWriteEn) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected actual addr=%0d data=%h required none",
                             coeffAddress, coeffsIn);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (coeffAddress !== e.a || coeffsIn !== e.d) begin
                        errors++;
                        $display("FAIL wr_data actual addr=%0d data=%h required addr=%0d data=%h",
                                 coeffAddress, coeffsIn, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {hostReady, coeffWriteEn, coeffAddress, coeffsIn,
                accelerateEn, clrC, busy, loadDone};
    endfunction

    // Start a load and feed coefficients base + i*step. stopAfter accepts
    // triggers an abort (or a reset pulse when useReset is set).
    task automatic do_load(input logic [15:0] base, input logic [15:0] step,
                           input int stallAfter, input int stallLen,
                           input int stopAfter, input bit useReset,
                           output int sc);
        int acc;
        int stalled;
        int guard;
        wr_t e;
        acc = 0;
        stalled = 0;
        guard = 0;
        @(posedge clk); #1;
        startLoad = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        startLoad = 1'b0;
        while (acc < N && guard < 100) begin
            guard++;
            if (acc == stopAfter) begin
                if (useReset) begin
                    rstN = 1'b0;
                    @(negedge clk); #1;
                    chk("rst_outs", outs(), 32'h0);
                    sb.delete();
                    hostValid = 1'b0;
                    @(posedge clk); #1;
                    rstN = 1'b1;
                end else begin
                    abortLoad = 1'b1;
                    hostValid = 1'b1;
                    @(posedge clk); #1;
                    abortLoad = 1'b0;
                    hostValid = 1'b0;
                end
                return;
            end
            if (acc == stallAfter && stalled < stallLen) begin
                hostValid = 1'b0;
                stalled++;
                @(posedge clk); #1;
                continue;
            end
            hostValid = 1'b1;
            hostCoeff = base + 16'(acc) * step;
            @(negedge clk);
            if (hostReady) begin
                e.a = 3'(acc);
                e.d = hostCoeff;
                sb.push_back(e);
                @(posedge clk); #1;
                acc++;
            end else begin
                @(posedge clk); #1;
            end
        end
        hostValid = 1'b0;
        if (guard >= 100) chk("feed_timeout", 32'(acc), 32'(N));
    endtask

    task automatic check_load(input string tag, input int sc, input int d0,
                              input int c0, input int lat, input bit accExp);
        int g;
        g = 0;
        while (nDone == d0 && g < 60) begin
            @(negedge clk); #1;
            g++;
        end
        chk({tag, "_done_cnt"}, 32'(nDone - d0), 32'd1);
        chk({tag, "_done_lat"}, 32'(doneCyc - sc), 32'(lat));
        chk({tag, "_clr_cnt"}, 32'(nClr - c0), 32'd1);
        chk({tag, "_clr_lat"}, 32'(clrCyc - sc), 32'(lat - 1));
        @(negedge clk); #1;
        chk({tag, "_accel"}, 32'(accelerateEn), 32'(accExp));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int sc;
        int d0;
        int c0;
        rstN = 1'b0;
        startLoad = 1'b0;
        abortLoad = 1'b0;
        hostValid = 1'b0;
        hostCoeff = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
        hostChecksum = '0;
`endif
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        // 1: idle after reset
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("idle_outs", outs(), 32'h0);
        chk("idle_accel", 32'(accelerateEn), 32'd0);

        // 2: full load of 0.2 in Q8.8 (51), hostValid held high
        d0 = nDone; c0 = nClr;
        do_load(16'd51, 16'd0, 99, 0, 99, 1'b0, sc);
        check_load("t2", sc, d0, c0, N + 3, 1'b1);

        // 3: two-cycle stall after the third coefficient
        d0 = nDone; c0 = nClr;
        do_load(16'h0100, 16'h0011, 3, 2, 99, 1'b0, sc);
        check_load("t3", sc, d0, c0, N + 5, 1'b1);

        // 4: abort after four accepts, with hostValid still high
        d0 = nDone; c0 = nClr;
        do_load(16'h0A00, 16'h0003, 99, 0, 4, 1'b0, sc);
        @(negedge clk); #1;
        chk("t4_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("t4_done_cnt", 32'(nDone - d0), 32'd0);
        chk("t4_clr_cnt", 32'(nClr - c0), 32'd0);
        chk("t4_accel", 32'(accelerateEn), 32'd0);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: reset mid-load, then reload starting the cycle after release
        do_load(16'h1234, 16'h0001, 99, 0, 2, 1'b1, sc);
        chk("t5_accel_after_rst", 32'(accelerateEn), 32'd0);
        d0 = nDone; c0 = nClr;
        do_load(16'hFF00, 16'h0001, 99, 0, 99, 1'b0, sc);
        check_load("t5", sc, d0, c0, N + 3, 1'b1);

`ifdef FIR_COEFF_CHECKSUM_EN
        // 6: checksum of eight 1.0 (Q8.8 = 0x0100) is 0x0800
        hostChecksum = 16'h0800;
        d0 = nDone; c0 = nClr;
        do_load(16'h0100, 16'h0000, 99, 0, 99, 1'b0, sc);
        check_load("t6a", sc, d0, c0, N + 3, 1'b1);
        chk("t6a_err", 32'(checksumErr), 32'd0);
        hostChecksum = 16'h0801;
        d0 = nDone; c0 = nClr;
        do_load(16'h0100, 16'h0000, 99, 0, 99, 1'b0, sc);
        check_load("t6b", sc, d0, c0, N + 3, 1'b0);
        chk("t6b_err", 32'(checksumErr), 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
